// File: rtl/multi_pid_controller_if.sv
// Configuration write bus for multi_pid_controller: one strobe, channel/register select, data.
interface multi_pid_controller_if;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;

  modport master (output cfg_we, cfg_ch, cfg_addr, cfg_data);
  modport slave  (input  cfg_we, cfg_ch, cfg_addr, cfg_data);
endinterface

// File: rtl/multi_pid_controller.sv
// Time-multiplexed PID engine: one sweep runs LOAD/MULT/ACCUM/STORE per channel, then DONE.
// Optional PID_INTEGRAL_LEAK_EN adds an integral leak of integral>>>8 ahead of each accumulate.
module multi_pid_controller #(
  parameter int NUM_CH = 8,
  parameter int OUT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  multi_pid_controller_if.slave   cfg,
  input  logic [32*NUM_CH-1:0]    position,
  input  logic [16*NUM_CH-1:0]    velocity,
  input  logic [16*NUM_CH-1:0]    displacement,
  input  logic                    update,
  output logic [OUT_W*NUM_CH-1:0] result,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);
  localparam logic signed [47:0] RMAX = (48'sd1 <<< (OUT_W-1)) - 48'sd1;
  localparam logic signed [47:0] RMIN = -RMAX - 48'sd1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MULT, S_ACCUM, S_STORE, S_DONE} state_e;

  typedef struct packed {
    logic [15:0] kp, ki, kd, fg;
    logic [31:0] sp;
    logic [15:0] out_pos, out_neg, int_pos, int_neg;
    logic [15:0] db;
    logic [1:0]  mode;
  } cfg_t;

  // Limits and Ki captured in MULT so mid-sweep writes cannot split a channel's update.
  typedef struct packed {
    logic [15:0] ki, out_pos, out_neg, int_pos, int_neg;
  } lim_t;

  function automatic logic signed [47:0] sx16(input logic [15:0] v);
    return {{32{v[15]}}, v};
  endfunction

  function automatic logic signed [47:0] sx32(input logic [31:0] v);
    return {{16{v[31]}}, v};
  endfunction

  function automatic logic signed [47:0] uz16(input logic [15:0] v);
    return {32'd0, v};
  endfunction

  function automatic logic signed [47:0] clamp(input logic signed [47:0] v, lo, hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic signed [47:0] v);
    logic signed [47:0] t;
    t = clamp(v, RMIN, RMAX);
    return t[OUT_W-1:0];
  endfunction

  state_e                          state_q, state_d;
  logic [CH_W-1:0]                 ch_q, ch_d;
  logic                            upd_q;
  logic                            ovr_q, ovr_d;
  cfg_t                            cfg_q [NUM_CH];
  cfg_t                            cfg_d [NUM_CH];
  logic signed [47:0]              integ_q [NUM_CH];
  logic signed [47:0]              integ_d [NUM_CH];
  logic signed [47:0]              lerr_q [NUM_CH];
  logic signed [47:0]              lerr_d [NUM_CH];
  logic [NUM_CH-1:0][OUT_W-1:0]    res_q, res_d;
  logic signed [47:0]              err_q, err_d;
  logic                            dbf_q, dbf_d;
  logic signed [47:0]              pterm_q, pterm_d, dterm_q, dterm_d, ff_q, ff_d;
  lim_t                            lim_q, lim_d;

  logic                            upd_edge;
  logic [31:0]                     ch_ix;
  cfg_t                            cc;
  logic [31:0]                     pos_c;
  logic [15:0]                     vel_c, dis_c;
  logic signed [47:0]              pv, err_c, acc, sum;
  logic [47:0]                     mag;
  logic                            in_db;
  logic [CH_W-1:0]                 wr_ix;

  assign upd_edge = update & ~upd_q;
  assign ch_ix    = 32'(ch_q);
  assign cc       = cfg_q[ch_q];
  assign pos_c    = position[ch_ix*32 +: 32];
  assign vel_c    = velocity[ch_ix*16 +: 16];
  assign dis_c    = displacement[ch_ix*16 +: 16];
  assign wr_ix    = cfg.cfg_ch[CH_W-1:0];

  assign result  = res_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign overrun = ovr_q;

  // Error and dead-band test for the channel currently in LOAD.
  always_comb begin
    pv = '0;
    case (cc.mode)
      2'd0:    pv = sx32(pos_c);
      2'd1:    pv = sx16(vel_c);
      2'd2:    pv = sx16(dis_c);
      default: pv = '0;
    endcase
    err_c = (cc.mode == 2'd3) ? 48'sd0 : sx32(cc.sp) - pv;
    mag   = err_c[47] ? -err_c : err_c;
    in_db = (mag <= {32'd0, cc.db});
  end

  always_comb begin
    cfg_d = cfg_q;
    if (cfg.cfg_we && ({1'b0, cfg.cfg_ch} < NUM_CH_L)) begin
      case (cfg.cfg_addr)
        4'd0:    cfg_d[wr_ix].kp      = cfg.cfg_data[15:0];
        4'd1:    cfg_d[wr_ix].ki      = cfg.cfg_data[15:0];
        4'd2:    cfg_d[wr_ix].kd      = cfg.cfg_data[15:0];
        4'd3:    cfg_d[wr_ix].sp      = cfg.cfg_data;
        4'd4:    cfg_d[wr_ix].fg      = cfg.cfg_data[15:0];
        4'd5:    cfg_d[wr_ix].out_pos = cfg.cfg_data[15:0];
        4'd6:    cfg_d[wr_ix].out_neg = cfg.cfg_data[15:0];
        4'd7:    cfg_d[wr_ix].int_pos = cfg.cfg_data[15:0];
        4'd8:    cfg_d[wr_ix].int_neg = cfg.cfg_data[15:0];
        4'd9:    cfg_d[wr_ix].db      = cfg.cfg_data[15:0];
        4'd10:   cfg_d[wr_ix].mode    = cfg.cfg_data[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ovr_d   = ovr_q;
    integ_d = integ_q;
    lerr_d  = lerr_q;
    res_d   = res_q;
    err_d   = err_q;
    dbf_d   = dbf_q;
    pterm_d = pterm_q;
    dterm_d = dterm_q;
    ff_d    = ff_q;
    lim_d   = lim_q;
    acc     = '0;
    sum     = '0;

    if (upd_edge && state_q != S_IDLE) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (upd_edge) begin
          ch_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        err_d   = err_c;
        dbf_d   = in_db;
        state_d = S_MULT;
      end
      S_MULT: begin
        pterm_d = uz16(cc.kp) * err_q;
        dterm_d = uz16(cc.kd) * (err_q - lerr_q[ch_q]);
        ff_d    = uz16(cc.fg) * sx32(cc.sp);
        lim_d   = '{ki: cc.ki, out_pos: cc.out_pos, out_neg: cc.out_neg,
                    int_pos: cc.int_pos, int_neg: cc.int_neg};
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        // Anti-windup: integrate only while the proportional term is inside the output window.
        if (!dbf_q && (sx16(lim_q.out_neg) < pterm_q) && (pterm_q < sx16(lim_q.out_pos))) begin
          acc = integ_q[ch_q];
`ifdef PID_INTEGRAL_LEAK_EN
          acc = acc - (acc >>> 8);
`else
`endif
          acc = acc + uz16(lim_q.ki) * err_q;
          integ_d[ch_q] = clamp(acc, sx16(lim_q.int_neg), sx16(lim_q.int_pos));
        end
        state_d = S_STORE;
      end
      S_STORE: begin
        sum = ff_q + pterm_q + integ_q[ch_q] + dterm_q;
        if (dbf_q)
          res_d[ch_q] = sat_out(integ_q[ch_q]);
        else if (sx16(lim_q.out_neg) > sx16(lim_q.out_pos))
          res_d[ch_q] = sat_out(sx16(lim_q.out_pos));
        else
          res_d[ch_q] = sat_out(clamp(sum, sx16(lim_q.out_neg), sx16(lim_q.out_pos)));
        lerr_d[ch_q] = err_q;
        if (ch_q == CH_W'(NUM_CH-1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      upd_q   <= 1'b0;
      ovr_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= '0;
      dbf_q   <= 1'b0;
      pterm_q <= '0;
      dterm_q <= '0;
      ff_q    <= '0;
      lim_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cfg_q[i]   <= '0;
        integ_q[i] <= '0;
        lerr_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      upd_q   <= update;
      ovr_q   <= ovr_d;
      res_q   <= res_d;
      err_q   <= err_d;
      dbf_q   <= dbf_d;
      pterm_q <= pterm_d;
      dterm_q <= dterm_d;
      ff_q    <= ff_d;
      lim_q   <= lim_d;
      cfg_q   <= cfg_d;
      integ_q <= integ_d;
      lerr_q  <= lerr_d;
    end
  end
endmodule

// File: tb/tb_multi_pid_controller.sv
// Directed bench for multi_pid_controller, two channels, hand-computed expected results.
module tb_multi_pid_controller;
  localparam int NCH = 2;
  localparam int OW  = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              update = 1'b0;
  logic [32*NCH-1:0] position = '0;
  logic [16*NCH-1:0] velocity = '0;
  logic [16*NCH-1:0] displacement = '0;
  logic [OW*NCH-1:0] result;
  logic              busy, done, overrun;
  int                n_tests = 0;
  int                n_fail = 0;
  int                cyc, nd;

  multi_pid_controller_if pif();

  multi_pid_controller #(.NUM_CH(NCH), .OUT_W(OW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg          (pif),
    .position     (position),
    .velocity     (velocity),
    .displacement (displacement),
    .update       (update),
    .result       (result),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint res(input int ch);
    logic signed [OW-1:0] r;
    r = result[ch*OW +: OW];
    return longint'(r);
  endfunction

  task automatic wr(input int ch, input int addr, input longint data);
    @(negedge clock);
    pif.cfg_we   = 1'b1;
    pif.cfg_ch   = 4'(ch);
    pif.cfg_addr = 4'(addr);
    pif.cfg_data = 32'(data);
    @(negedge clock);
    pif.cfg_we   = 1'b0;
  endtask

  // Drives one update edge; cyc = cycles from start edge to done, nd = done pulses seen.
  task automatic sweep(output int c, output int n);
    @(negedge clock);
    update = 1'b1;
    @(posedge clock); #1;
    update = 1'b0;
    c = 1;
    n = 0;
    while (!done && c < 40) begin
      @(posedge clock); #1;
      c++;
    end
    if (done) n = 1;
    repeat (4) begin
      @(posedge clock); #1;
      if (done) n++;
    end
  endtask

  initial begin
    pif.cfg_we = 1'b0; pif.cfg_ch = '0; pif.cfg_addr = '0; pif.cfg_data = '0;
    #12;
    chk("rst_result", longint'(result), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic proportional path, plus out-of-range writes that must not alias onto ch0
    wr(0, 0, 2); wr(0, 3, 100); wr(0, 5, 1000); wr(0, 6, -1000);
    wr(2, 0, 500); wr(0, 11, 0);
    position[31:0] = 32'd40;
    sweep(cyc, nd);
    chk("p_latency", cyc, 9);
    chk("p_done_cnt", nd, 1);
    chk("p_busy_after", busy, 0);
    chk("p_result0", res(0), 120);
    chk("p_result1", res(1), 0);
    chk("p_overrun", overrun, 0);

    // Output clamp with no integration; ch1 has inverted limits
    wr(0, 0, 100); wr(0, 1, 1); wr(0, 7, 1000); wr(0, 8, -1000);
    wr(1, 0, 1); wr(1, 3, 100); wr(1, 5, -5); wr(1, 6, 5);
    position[31:0] = 32'd50;
    sweep(cyc, nd);
    chk("clamp_result0", res(0), 1000);
    chk("inv_limits_r1", res(1), -5);
    wr(0, 0, 0); wr(0, 9, 100);
    sweep(cyc, nd);
    chk("clamp_integ_kept", res(0), 0);

    // Dead band holds the integral
    wr(0, 9, 0);
    position[31:0] = 32'd63;
    sweep(cyc, nd);
    chk("integ_37", res(0), 37);
    wr(0, 9, 10);
    position[31:0] = 32'd95;
    sweep(cyc, nd);
    chk("deadband_r0", res(0), 37);
    wr(0, 9, 0); wr(0, 1, 0);
    sweep(cyc, nd);
    chk("deadband_integ", res(0), 37);

    // Reset during ch1 STORE: ch1 still shows last sweep's value, then all clears
    wr(1, 5, 7); wr(1, 6, -7);
    @(negedge clock);
    update = 1'b1;
    @(posedge clock); #1;
    update = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    chk("mid_r0_new", res(0), 37);
    chk("mid_r1_held", res(1), -5);
    reset_n = 1'b0;
    #1;
    chk("abort_result", longint'(result), 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    nd = 0;
    repeat (2) begin @(negedge clock); if (done) nd++; end
    reset_n = 1'b1;
    repeat (10) begin @(negedge clock); if (done || busy) nd++; end
    chk("abort_no_done", nd, 0);

    // Integral accumulation and saturation at intPos
    wr(0, 1, 1); wr(0, 3, 100); wr(0, 7, 25); wr(0, 8, -1000);
    wr(0, 5, 1000); wr(0, 6, -1000);
    position[31:0] = 32'd90;
    sweep(cyc, nd);
    chk("post_rst_latency", cyc, 9);
    chk("post_rst_done", nd, 1);
    chk("integ_s1", res(0), 10);
    sweep(cyc, nd);
    chk("integ_s2", res(0), 20);
    sweep(cyc, nd);
    chk("integ_s3", res(0), 25);
    sweep(cyc, nd);
    chk("integ_s4", res(0), 25);

    // Derivative, feed-forward and the mode select
    wr(0, 1, 0); wr(0, 2, 1);
    position[31:0] = 32'd70;
    sweep(cyc, nd);
    chk("dterm", res(0), 45);
    wr(0, 2, 0); wr(0, 4, 1);
    sweep(cyc, nd);
    chk("ffwd", res(0), 125);
    wr(0, 4, 0); wr(0, 0, 1); wr(0, 10, 1);
    velocity[15:0] = 16'hFFEC;
    sweep(cyc, nd);
    chk("mode_vel", res(0), 145);
    wr(0, 10, 2);
    displacement[15:0] = 16'hFFE2;
    sweep(cyc, nd);
    chk("mode_disp", res(0), 155);
    wr(0, 10, 3);
    sweep(cyc, nd);
    chk("mode_zero", res(0), 25);
    chk("no_ovr_yet", overrun, 0);

    // Second edge three cycles into a sweep
    @(negedge clock);
    update = 1'b1;
    @(posedge clock); #1;
    update = 1'b0;
    @(posedge clock); #1;
    update = 1'b1;
    @(posedge clock); #1;
    update = 1'b0;
    nd = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done) nd++;
    end
    chk("ovr_done_cnt", nd, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_busy", busy, 0);
    sweep(cyc, nd);
    chk("ovr_sticky", overrun, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
